fifo_drain_tx: RTL and testbench

Read-side consumer for the 3-bit, 5-deep FIFO. It watches the FIFO empty flag, pops one word at a time through the FIFO `rd`/`datout` interface, and serializes each word onto a UART-style line: start bit, 3 data bits LSB first, optional parity, stop bit. It runs in the FIFO read clock domain and is the FIFO's only reader.

---
 rtl/fifo_tx_pkg.sv | 8 +
 rtl/fifo_tx_baud.sv | 18 +
 rtl/fifo_drain_tx.sv | 84 ++++++++
 tb/tb_fifo_drain_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg: shared states, default word width and counter sizing for the FIFO drain transmitter
package fifo_tx_pkg;
    typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, PAR, STOP} state_t;
    localparam int FIFO_DW = 3;
    function automatic int bit_cnt_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction
endpackage

// File: rtl/fifo_tx_baud.sv
// fifo_tx_baud: bit-timing counter; bit_end marks the last cycle of a bit, bit_pre the cycle before it
module fifo_tx_baud import fifo_tx_pkg::*; #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic rclk,
    input  logic rst,
    input  logic clr,
    output logic bit_end,
    output logic bit_pre
);
    localparam int CW = bit_cnt_w(CLKS_PER_BIT);
    logic [CW-1:0] cnt;
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign bit_pre = cnt == CW'(CLKS_PER_BIT - 2);
    always_ff @(posedge rclk or negedge rst)
        if (!rst) cnt <= '0;
        else      cnt <= (clr || bit_end) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/fifo_drain_tx.sv
// fifo_drain_tx: pops words from the FIFO read side and sends each as a UART-style frame
// Define FIFO_TX_PARITY_EN to add an even-parity bit after the data bits.
module fifo_drain_tx import fifo_tx_pkg::*; #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DW           = FIFO_DW
) (
    input  logic          rclk,
    input  logic          rst,
    input  logic          en,
    input  logic          empy,
    input  logic [DW-1:0] datout,
    output logic          rd,
    output logic          txd,
    output logic          busy,
    output logic          frame_done
);
    localparam int IW = $clog2(DW) + 1;
    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [DW-1:0] sh, sh_n;
    logic          txd_n, bit_end, bit_pre, clr;
    assign clr = state inside {IDLE, POP, WAIT};
    fifo_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .rclk(rclk), .rst(rst), .clr(clr), .bit_end(bit_end), .bit_pre(bit_pre)
    );
`ifdef FIFO_TX_PARITY_EN
    logic par;
    always_ff @(posedge rclk or negedge rst)
        if (!rst)               par <= 1'b0;
        else if (state == WAIT) par <= ^datout;
`endif
    always_comb begin
        state_n = state;
        idx_n   = idx;
        sh_n    = sh;
        case (state)
            IDLE:  if (en && !empy) state_n = POP;
            POP:   state_n = WAIT;
            WAIT:  begin sh_n = datout; state_n = START; end
            START: if (bit_end) begin state_n = DATA; idx_n = '0; end
            DATA:  if (bit_end) begin
                       if (idx == IW'(DW - 1))
`ifdef FIFO_TX_PARITY_EN
                           state_n = PAR;
`else
                           state_n = STOP;
`endif
                       else begin
                           idx_n = idx + IW'(1);
                           sh_n  = sh >> 1;
                       end
                   end
`ifdef FIFO_TX_PARITY_EN
            PAR:   if (bit_end) state_n = STOP;
`endif
            STOP:  if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // line level is decided one cycle early so txd comes straight from a flop
`ifdef FIFO_TX_PARITY_EN
        txd_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PAR ? par : 1'b1;
`else
        txd_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
`endif
    end
    always_ff @(posedge rclk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            sh         <= '0;
            rd         <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            sh         <= sh_n;
            rd         <= state_n == POP;
            txd        <= txd_n;
            busy       <= state_n != IDLE;
            frame_done <= state == STOP && bit_pre;
        end
endmodule

// File: tb/tb_fifo_drain_tx.sv
// tb_fifo_drain_tx: directed checks of fifo_drain_tx against a behavioural FIFO and hand-built frames
module tb_fifo_drain_tx;
    localparam int CPB = 16;
    localparam int DW  = 3;
`ifdef FIFO_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int FLEN = 1 + NB * CPB;
    logic          rclk = 1'b0, rst = 1'b0, en = 1'b0, empy = 1'b1;
    logic [DW-1:0] datout = '0;
    logic          rd, txd, busy, frame_done;
    int            cyc = 0, pops = 0, n_cmp = 0, n_bad = 0;
    logic [DW-1:0] q[$];

    fifo_drain_tx #(.CLKS_PER_BIT(CPB), .DW(DW)) dut (
        .rclk(rclk), .rst(rst), .en(en), .empy(empy), .datout(datout),
        .rd(rd), .txd(txd), .busy(busy), .frame_done(frame_done)
    );

    always #5 rclk = ~rclk;
    always @(posedge rclk) cyc <= cyc + 1;

    // FIFO read side: data appears after the pop edge, empty flag follows the queue
    always @(negedge rclk)
        if (rd) begin
            pops++;
            if (q.size() > 0) datout = q.pop_front();
            empy = (q.size() == 0);
        end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        q.push_back(w);
        empy = 1'b0;
    endtask

    function automatic logic [7:0] frm(input logic [DW-1:0] w);
`ifdef FIFO_TX_PARITY_EN
        return {2'b00, 1'b1, ^w, w, 1'b0};
`else
        return {3'b000, 1'b1, w, 1'b0};
`endif
    endfunction

    // offset 0 is the rd cycle; bits are sampled mid-bit, frame_done must land on the last offset
    task automatic recv(input int drop_at, input int abort_at, output logic [7:0] bits, output int t0);
        int fd;
        bits = '0;
        t0   = -1;
        fd   = 0;
        for (int i = 0; i < 300 && !rd; i++) @(negedge rclk);
        if (!rd) begin
            check("rd_timeout", 0, 1);
            return;
        end
        t0 = cyc;
        for (int k = 1; k <= FLEN; k++) begin
            @(negedge rclk);
            if (k == drop_at) en = 1'b0;
            if (k == abort_at) return;
            if (k == 1) begin
                check("rd_one_cycle", rd, 0);
                check("txd_high_in_wait", txd, 1);
            end
            if (k == 2) check("txd_start_fall", txd, 0);
            if (k >= 2 && (k - 2) % CPB == CPB / 2) bits[(k - 2) / CPB] = txd;
            fd += int'(frame_done);
        end
        check("frame_done_last", frame_done, 1);
        check("frame_done_once", fd, 1);
        check("busy_in_stop", busy, 1);
    endtask

    initial begin
        logic [7:0] b;
        int t, tp;
        repeat (5) begin
            @(negedge rclk);
            check("rst_txd", txd, 1);
            check("rst_rd", rd, 0);
            check("rst_busy", busy, 0);
        end
        rst = 1'b1;
        en  = 1'b1;
        repeat (100) @(negedge rclk);
        check("idle_no_rd", pops, 0);
        check("idle_txd", txd, 1);

        push(3'b101);
        recv(0, 0, b, t);
        check("single_frame", b, frm(3'b101));
        @(negedge rclk);
        check("single_busy_off", busy, 0);
        check("single_pops", pops, 1);

        for (int i = 1; i <= 5; i++) push(3'(i));
        tp = -1;
        for (int i = 1; i <= 5; i++) begin
            recv(0, 0, b, t);
            check("burst_frame", b, frm(3'(i)));
            if (i > 1) check("burst_gap", t - tp, FLEN + 2);
            tp = t;
        end
        check("burst_empty", empy, 1);
        repeat (100) @(negedge rclk);
        check("burst_pops", pops, 6);

        push(3'b011);
        push(3'b111);
        recv(0, 0, b, t);
        check("frame_011", b, frm(3'b011));
`ifdef FIFO_TX_PARITY_EN
        check("par_011", b[4], 0);
`endif
        recv(0, 0, b, t);
        check("frame_111", b, frm(3'b111));
`ifdef FIFO_TX_PARITY_EN
        check("par_111", b[4], 1);
`endif
        check("parity_pops", pops, 8);

        push(3'b110);
        push(3'b001);
        recv(30, 0, b, t);
        check("en_frame1", b, frm(3'b110));
        repeat (50) @(negedge rclk);
        check("en_low_pops", pops, 9);
        check("en_low_busy", busy, 0);
        check("en_low_queued", empy, 0);
        en = 1'b1;
        recv(0, 0, b, t);
        check("en_frame2", b, frm(3'b001));
        check("en_pops", pops, 10);

        push(3'b101);
        push(3'b011);
        recv(0, 40, b, t);
        check("pre_rst_txd", txd, 0);
        rst = 1'b0;
        #1;
        check("async_rst_txd", txd, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_rd", rd, 0);
        repeat (3) @(negedge rclk);
        rst = 1'b1;
        recv(0, 0, b, t);
        check("post_rst_frame", b, frm(3'b011));
        repeat (20) @(negedge rclk);
        check("post_rst_pops", pops, 12);
        check("post_rst_empty", empy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
